spi_xfer_sched: RTL and testbench

//  Round-robin scheduler that shares the SPI master between N_REQ on-chip requesters.

---
 rtl/spi_xfer_sched.sv | 191 +++++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sched.sv
// rtl/spi_xfer_sched.sv - round-robin scheduler sharing one SPI master between N_REQ requesters
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req / req_data           per-requester request level and tx byte (byte i at [8i+7:8i])
//   gnt                      one-hot single-cycle pulse when a request is accepted
//   rsp_valid/id/data/err    single-cycle response: received byte, or timeout abort
//   busy                     high whenever a transfer is in flight
//   sfrwe/sfraddr_w/spidata_o  SFR write port towards the SPI master
//   sfraddr_r/sfr_data_i     SFR read port; read data arrives one cycle after the address
//   spssn_o                  active-low chip selects, requester i owns bit i
module spi_xfer_sched #(
    parameter int         N_REQ   = 4,
    parameter logic [7:0] CR1_CFG = 8'h10,
    parameter logic [7:0] BR_CFG  = 8'h03,
    parameter int         TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    output logic [2:0]         rsp_id,
    output logic [7:0]         rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               sfrwe,
    output logic [2:0]         sfraddr_w,
    output logic [2:0]         sfraddr_r,
    output logic [7:0]         spidata_o,
    input  logic [7:0]         sfr_data_i,
    output logic [7:0]         spssn_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CR1, S_WR_BR, S_WR_DR, S_POLL_LO,
        S_POLL_HI, S_RD_ADR, S_RD_DAT, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       w_q, w_d;
    logic [7:0]       tx_q, tx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       raddr_q, raddr_d;

    logic             found;
    logic [2:0]       pick;
    logic [7:0]       pick_data;

    // Search ptr..N_REQ-1 first, then wrap to 0..ptr-1.
    always_comb begin
        found     = 1'b0;
        pick      = 3'd0;
        pick_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr_q)) begin
                found     = 1'b1;
                pick      = 3'(i);
                pick_data = req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                pick      = 3'(i);
                pick_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        tx_d      = tx_q;
        tmo_d     = tmo_q;
        gnt_d     = '0;
        raddr_d   = raddr_q;
        sfrwe     = 1'b0;
        sfraddr_w = 3'd0;
        spidata_o = 8'h00;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        gnt_d[i] = (3'(i) == pick);
                    end
                    w_d     = pick;
                    tx_d    = pick_data;
                    ptr_d   = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
                    state_d = S_WR_CR1;
                end
            end
            S_WR_CR1: begin
                sfrwe     = 1'b1;
                sfraddr_w = 3'd0;
                spidata_o = CR1_CFG | 8'h10;
                state_d   = S_WR_BR;
            end
            S_WR_BR: begin
                sfrwe     = 1'b1;
                sfraddr_w = 3'd2;
                spidata_o = BR_CFG;
                state_d   = S_WR_DR;
            end
            S_WR_DR: begin
                sfrwe     = 1'b1;
                sfraddr_w = 3'd3;
                spidata_o = tx_q;
                tmo_d     = '0;
                state_d   = S_POLL_LO;
            end
            S_POLL_LO: begin
                raddr_d = 3'd3;
                tmo_d   = tmo_q + TW'(1);
                // tmo_q==0 marks the first poll cycle, whose read data still
                // belongs to the address presented before polling started.
                if (tmo_q != '0 && !sfr_data_i[0]) begin
                    state_d = S_POLL_HI;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_POLL_HI: begin
                raddr_d = 3'd3;
                tmo_d   = tmo_q + TW'(1);
                if (sfr_data_i[0]) begin
                    state_d = S_RD_ADR;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_RD_ADR: begin
                raddr_d = 3'd5;
                state_d = S_RD_DAT;
            end
            S_RD_DAT: begin
                rsp_valid = 1'b1;
                rsp_data  = sfr_data_i;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spssn_o = 8'hFF;
        if (state_q != S_IDLE && state_q != S_ERR) begin
            spssn_o = ~(8'h01 << w_q);
        end
    end

    assign sfraddr_r = raddr_d;
    assign rsp_id    = rsp_valid ? w_q : 3'd0;
    assign busy      = (state_q != S_IDLE);
    assign gnt       = gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            w_q     <= 3'd0;
            tx_q    <= 8'h00;
            tmo_q   <= '0;
            gnt_q   <= '0;
            raddr_q <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            tx_q    <= tx_d;
            tmo_q   <= tmo_d;
            gnt_q   <= gnt_d;
            raddr_q <= raddr_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb/tb_spi_xfer_sched.sv - scoreboard bench for spi_xfer_sched with an SFR slave model
module tb_spi_xfer_sched;

    localparam int N   = 4;
    localparam int TMO = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [2:0]     rsp_id;
    logic [7:0]     rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           sfrwe;
    logic [2:0]     sfraddr_w;
    logic [2:0]     sfraddr_r;
    logic [7:0]     spidata_o;
    logic [7:0]     sfr_data_i = 8'h00;
    logic [7:0]     spssn_o;

    spi_xfer_sched #(.N_REQ(N), .CR1_CFG(8'h10), .BR_CFG(8'h03), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .sfraddr_r(sfraddr_r),
        .spidata_o(spidata_o), .sfr_data_i(sfr_data_i), .spssn_o(spssn_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SFR slave: SPISR[0] reads 1 (stale) for `stale` cycles after the DR write,
    // then 0 for `busyc` cycles, then 1; with `hang` it never rises again.
    int         k = 100;
    bit         hang = 1'b0;
    int         stale = 0;
    int         busyc = 3;
    logic [7:0] tx_seen = 8'h00;

    function automatic bit status(input int kk);
        if (kk < stale) return 1'b1;
        if (hang) return 1'b0;
        return (kk >= stale + busyc);
    endfunction

    always @(posedge clk) begin
        case (sfraddr_r)
            3'd3:    sfr_data_i <= {7'b0, status(k)};
            3'd5:    sfr_data_i <= tx_seen ^ 8'h99;
            default: sfr_data_i <= 8'h00;
        endcase
        if (sfrwe && sfraddr_w == 3'd3) begin
            tx_seen <= spidata_o;
            k       <= 0;
        end else if (k < 1000) begin
            k <= k + 1;
        end
    end

    // Reference model: round-robin pointer plus expected grant/response queues.
    typedef struct {
        int         id;
        logic [7:0] tx;
        logic [7:0] data;
        bit         err;
    } exp_t;

    exp_t       exp_gq[$];
    exp_t       exp_rq[$];
    int         ptr_m = 0;
    logic [7:0] tx_m[N];

    function automatic int model_pick(input logic [N-1:0] pend);
        for (int s = 0; s < N; s++) begin
            int c;
            c = (ptr_m + s) % N;
            if (pend[c]) begin
                ptr_m = (c + 1) % N;
                return c;
            end
        end
        return 0;
    endfunction

    task automatic push_xfer(input int id);
        exp_t e;
        e.id   = id;
        e.tx   = tx_m[id];
        e.err  = hang;
        e.data = hang ? 8'h00 : (tx_m[id] ^ 8'h99);
        exp_gq.push_back(e);
        exp_rq.push_back(e);
    endtask

    // Monitor / scoreboard.
    initial begin
        int         out;
        int         wr;
        int         dr_cyc;
        bit         have;
        logic [2:0] praddr;
        logic [2:0] ea;
        logic [7:0] ed;
        logic [7:0] ess;
        exp_t       cur;
        exp_t       e;
        out = 0; wr = 0; dr_cyc = 0; have = 1'b0; praddr = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out = 0; wr = 0; have = 1'b0; praddr = 3'd0;
                continue;
            end
            if (gnt != '0) begin
                if (exp_gq.size() == 0) begin
                    chk("unexpected_gnt", gnt, 0);
                end else begin
                    cur = exp_gq.pop_front();
                    have = 1'b1;
                    chk("gnt_onehot", gnt, 32'd1 << cur.id);
                    chk("one_rsp_between_gnts", out, 0);
                    out = 1;
                    wr = 0;
                end
            end
            if (sfrwe) begin
                chk("write_in_xfer", {31'd0, have && wr < 3}, 1);
                ea  = (wr == 0) ? 3'd0 : (wr == 1) ? 3'd2 : 3'd3;
                ed  = (wr == 0) ? 8'h10 : (wr == 1) ? 8'h03 : cur.tx;
                ess = ~(8'h01 << cur.id);
                chk("sfr_waddr", sfraddr_w, ea);
                chk("sfr_wdata", spidata_o, ed);
                chk("spssn_xfer", spssn_o, ess);
                if (sfraddr_w == 3'd3) dr_cyc = cyc;
                wr++;
            end
            if (sfraddr_r == 3'd5 && praddr == 3'd3) begin
                chk("no_early_read", {31'd0, (k >= stale + busyc + 2) && !hang}, 1);
            end
            praddr = sfraddr_r;
            if (rsp_valid) begin
                if (exp_rq.size() == 0) begin
                    chk("unexpected_rsp", rsp_id, 32'hFFFF);
                end else begin
                    e = exp_rq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_after_gnt", out, 1);
                    out = 0;
                    if (e.err) begin
                        chk("err_latency", cyc, dr_cyc + 1 + TMO);
                        chk("spssn_err", spssn_o, 8'hFF);
                    end else begin
                        ess = ~(8'h01 << e.id);
                        chk("spssn_rd", spssn_o, ess);
                    end
                end
            end
        end
    end

    // Requesters drop their request on grant; hold mode keeps all raised for hold_left responses.
    int hold_left = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (hold_left > 0) begin
                if (rsp_valid) begin
                    hold_left--;
                    if (hold_left == 0) req = '0;
                end
            end else begin
                req = req & ~gnt;
            end
        end
    end

    task automatic start_round(input logic [N-1:0] set, input bit hg, input int st,
                               input int bz, input bit rnd);
        logic [N-1:0] pend;
        int w;
        hang  = hg;
        stale = st;
        busyc = bz;
        for (int i = 0; i < N; i++) begin
            if (set[i]) begin
                if (rnd) tx_m[i] = 8'($urandom);
                req_data[8*i +: 8] = tx_m[i];
            end
        end
        pend = set;
        while (pend != '0) begin
            w = model_pick(pend);
            push_xfer(w);
            pend[w] = 1'b0;
        end
        req = req | set;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_rq.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            chk("drain_timeout", exp_rq.size(), 0);
            exp_rq.delete();
            exp_gq.delete();
            hold_left = 0;
            req = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        int t;
        for (int i = 0; i < N; i++) tx_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sfrwe", sfrwe, 0);
        chk("rst_spssn", spssn_o, 8'hFF);
        chk("rst_sfraddr_r", sfraddr_r, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_write", sfrwe, 0);

        // All requesters held: grants 0,1,2,3,0 from the reset pointer.
        hang = 1'b0; stale = 2; busyc = 3;
        for (int i = 0; i < N; i++) begin
            tx_m[i] = 8'($urandom);
            req_data[8*i +: 8] = tx_m[i];
        end
        for (int n = 0; n < 5; n++) push_xfer(model_pick(4'b1111));
        hold_left = 5;
        req = 4'b1111;
        wait_drain();

        // Single requester 2 with 8'hA5; slave echoes 8'h3C.
        tx_m[2] = 8'hA5;
        start_round(4'b0100, 1'b0, 1, 2, 1'b0);
        wait_drain();

        // Stale done flag held high for 5 poll cycles.
        start_round(4'b0010, 1'b0, 5, 3, 1'b1);
        wait_drain();

        // Done flag never rises: timeout abort.
        start_round(4'b0001, 1'b1, 2, 1, 1'b1);
        wait_drain();

        // Reset while waiting in POLL_HI.
        start_round(4'b0100, 1'b1, 0, 1, 1'b1);
        t = 0;
        while (!(sfrwe && sfraddr_w == 3'd3) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("dr_write_seen", {31'd0, sfrwe && sfraddr_w == 3'd3}, 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_spssn", spssn_o, 8'hFF);
        chk("arst_busy", busy, 0);
        chk("arst_sfrwe", sfrwe, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        exp_rq.delete();
        exp_gq.delete();
        ptr_m = 0;
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        start_round(4'b1010, 1'b0, 1, 2, 1'b1);
        wait_drain();

        // req0 raised while requester 3 is being served.
        start_round(4'b1000, 1'b0, 3, 2, 1'b1);
        t = 0;
        while (!gnt[3] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("gnt3_seen", gnt[3], 1);
        tx_m[0] = 8'($urandom);
        req_data[7:0] = tx_m[0];
        push_xfer(model_pick(4'b0001));
        req[0] = 1'b1;
        wait_drain();

        // Randomised rounds.
        for (int r = 0; r < 14; r++) begin
            logic [N-1:0] set;
            set = 4'($urandom_range(1, 15));
            start_round(set, ($urandom_range(0, 4) == 0), $urandom_range(0, 6),
                        $urandom_range(1, 6), 1'b1);
            wait_drain();
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
